// File: rtl/sw_scoring_engine_if.sv
// Target base stream into the Smith-Waterman scoring engine.
// The source drives valid/data/last; the engine answers with ready.
interface sw_scoring_engine_if;
    logic       tgt_valid;
    logic       tgt_ready;
    logic [1:0] tgt_data;
    logic       tgt_last;

    modport master (output tgt_valid, tgt_data, tgt_last, input tgt_ready);
    modport slave  (input tgt_valid, tgt_data, tgt_last, output tgt_ready);
endinterface

// File: rtl/sw_scoring_engine.sv
// Systolic Smith-Waterman local-alignment scorer with affine gaps.
// Each target base ripples through a linear array of PEs, one PE per query base.
module sw_scoring_engine #(
    parameter int SCORE_WIDTH = 12,
    parameter int LENGTH      = 16,
    parameter int LOG_LENGTH  = $clog2(LENGTH + 1)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [2*LENGTH-1:0]      query,
    input  logic [LOG_LENGTH-1:0]    query_len,
    input  logic [SCORE_WIDTH-1:0]   match,
    input  logic [SCORE_WIDTH-1:0]   mismatch,
    input  logic [SCORE_WIDTH-1:0]   gap_open,
    input  logic [SCORE_WIDTH-1:0]   gap_extend,
    sw_scoring_engine_if.slave       tgt,
    output logic [SCORE_WIDTH-1:0]   result,
    output logic                     result_valid,
    output logic                     busy
);
    localparam int IW = (LENGTH > 1) ? $clog2(LENGTH) : 1;
    localparam logic [LOG_LENGTH-1:0] LEN_MAX = LOG_LENGTH'(LENGTH);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
    typedef logic [SCORE_WIDTH-1:0] score_t;

    function automatic score_t sub_floor(input score_t a, input score_t b);
        return (a > b) ? score_t'(a - b) : '0;
    endfunction

    function automatic score_t add_sat(input score_t a, input score_t b);
        logic [SCORE_WIDTH:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[SCORE_WIDTH] ? '1 : s[SCORE_WIDTH-1:0];
    endfunction

    function automatic score_t max2(input score_t a, input score_t b);
        return (a > b) ? a : b;
    endfunction

    state_t                  state_q, state_d;
    logic [LOG_LENGTH-1:0]   qlen_q, qlen_d, cnt_q, cnt_d, qlen_in;
    logic [2*LENGTH-1:0]     query_q, query_d;
    score_t                  match_q, match_d, mism_q, mism_d;
    score_t                  gopen_q, gopen_d, gext_q, gext_d;
    score_t                  result_q, result_d;
    logic                    in_vld_q, in_vld_d;
    logic [1:0]              in_base_q, in_base_d;
    logic [IW-1:0]           last_idx;
    logic                    hs, adv, clr;

    score_t     h_q [LENGTH], h_d [LENGTH], e_q [LENGTH], e_d [LENGTH];
    score_t     f_q [LENGTH], f_d [LENGTH], hi_q [LENGTH], hi_d [LENGTH];
    score_t     dg_q [LENGTH], dg_d [LENGTH];
    logic [1:0] base_q [LENGTH], base_d [LENGTH];
    logic       vld_q [LENGTH], vld_d [LENGTH];

    assign tgt.tgt_ready = (state_q == RUN);
    assign hs            = tgt.tgt_valid & tgt.tgt_ready;
    // The array only moves on an accepted beat or while draining, so stalls freeze every PE.
    assign adv           = hs | (state_q == DRAIN);
    assign clr           = (state_q == IDLE) & start;
    assign qlen_in       = (query_len > LEN_MAX) ? LEN_MAX : query_len;
    assign last_idx      = IW'(qlen_q - LOG_LENGTH'(1));
    assign busy          = (state_q != IDLE);
    assign result_valid  = (state_q == DONE);
    assign result        = result_q;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        qlen_d   = qlen_q;
        query_d  = query_q;
        match_d  = match_q;
        mism_d   = mism_q;
        gopen_d  = gopen_q;
        gext_d   = gext_q;
        result_d = result_q;
        case (state_q)
            IDLE: if (start) begin
                qlen_d   = qlen_in;
                query_d  = query;
                match_d  = match;
                mism_d   = mismatch;
                gopen_d  = gap_open;
                gext_d   = gap_extend;
                result_d = '0;
                state_d  = (qlen_in == '0) ? DONE : RUN;
            end
            RUN: if (hs && tgt.tgt_last) begin
                state_d = DRAIN;
                cnt_d   = '0;
            end
            DRAIN: begin
                if (cnt_q == qlen_q) begin
                    state_d  = DONE;
                    result_d = hi_q[last_idx];
                end else begin
                    cnt_d = cnt_q + LOG_LENGTH'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        score_t     hl, fl, hil, ds, en, fn, hn;
        logic       vin;
        logic [1:0] bin;
        hl = '0; fl = '0; hil = '0; ds = '0; en = '0; fn = '0; hn = '0;
        vin = 1'b0; bin = '0;
        in_vld_d  = in_vld_q;
        in_base_d = in_base_q;
        for (int i = 0; i < LENGTH; i++) begin
            h_d[i] = h_q[i]; e_d[i] = e_q[i]; f_d[i] = f_q[i];
            hi_d[i] = hi_q[i]; dg_d[i] = dg_q[i];
            base_d[i] = base_q[i]; vld_d[i] = vld_q[i];
        end
        if (clr) begin
            in_vld_d = 1'b0;
            for (int i = 0; i < LENGTH; i++) begin
                h_d[i] = '0; e_d[i] = '0; f_d[i] = '0; hi_d[i] = '0; dg_d[i] = '0;
                vld_d[i] = 1'b0;
            end
        end else if (adv) begin
            in_vld_d  = hs;
            in_base_d = tgt.tgt_data;
            for (int i = 0; i < LENGTH; i++) begin
                vin = (i == 0) ? in_vld_q  : vld_q[(i > 0) ? i - 1 : 0];
                bin = (i == 0) ? in_base_q : base_q[(i > 0) ? i - 1 : 0];
                hl  = (i == 0) ? '0 : h_q[(i > 0) ? i - 1 : 0];
                fl  = (i == 0) ? '0 : f_q[(i > 0) ? i - 1 : 0];
                hil = (i == 0) ? '0 : hi_q[(i > 0) ? i - 1 : 0];
                vld_d[i]  = vin;
                base_d[i] = bin;
                if (vin) begin
                    ds = (query_q[2*i +: 2] == bin) ? add_sat(dg_q[i], match_q)
                                                    : sub_floor(dg_q[i], mism_q);
                    en = max2(sub_floor(h_q[i], gopen_q), sub_floor(e_q[i], gext_q));
                    fn = max2(sub_floor(hl, gopen_q), sub_floor(fl, gext_q));
                    hn = max2(ds, max2(en, fn));
                    h_d[i]  = hn;
                    e_d[i]  = en;
                    f_d[i]  = fn;
                    hi_d[i] = max2(hi_q[i], max2(hil, hn));
                    dg_d[i] = hl;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE; cnt_q <= '0; qlen_q <= '0; query_q <= '0;
            match_q <= '0; mism_q <= '0; gopen_q <= '0; gext_q <= '0;
            result_q <= '0; in_vld_q <= 1'b0; in_base_q <= '0;
            for (int i = 0; i < LENGTH; i++) begin
                h_q[i] <= '0; e_q[i] <= '0; f_q[i] <= '0; hi_q[i] <= '0; dg_q[i] <= '0;
                base_q[i] <= '0; vld_q[i] <= 1'b0;
            end
        end else begin
            state_q <= state_d; cnt_q <= cnt_d; qlen_q <= qlen_d; query_q <= query_d;
            match_q <= match_d; mism_q <= mism_d; gopen_q <= gopen_d; gext_q <= gext_d;
            result_q <= result_d; in_vld_q <= in_vld_d; in_base_q <= in_base_d;
            for (int i = 0; i < LENGTH; i++) begin
                h_q[i] <= h_d[i]; e_q[i] <= e_d[i]; f_q[i] <= f_d[i];
                hi_q[i] <= hi_d[i]; dg_q[i] <= dg_d[i];
                base_q[i] <= base_d[i]; vld_q[i] <= vld_d[i];
            end
        end
    end
endmodule

// File: tb/tb_sw_scoring_engine.sv
// Bench for sw_scoring_engine: directed jobs checked against a full dynamic-programming
// Smith-Waterman model, with result timing checked every cycle.
module tb_sw_scoring_engine;
    localparam int SW   = 12;
    localparam int LEN  = 16;
    localparam int LL   = 5;
    localparam int MAXS = 4095;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic [2*LEN-1:0]  query;
    logic [LL-1:0]     query_len;
    logic [SW-1:0]     match, mismatch, gap_open, gap_extend;
    logic [SW-1:0]     result;
    logic              result_valid, busy;

    sw_scoring_engine_if tif ();

    sw_scoring_engine #(.SCORE_WIDTH(SW), .LENGTH(LEN), .LOG_LENGTH(LL)) dut (
        .clk(clk), .rst(rst), .start(start), .query(query), .query_len(query_len),
        .match(match), .mismatch(mismatch), .gap_open(gap_open), .gap_extend(gap_extend),
        .tgt(tif), .result(result), .result_valid(result_valid), .busy(busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int passes = 0;
    int exp_cycle = -1;
    int exp_res = 0;

    logic [1:0] mq [LEN];
    logic [1:0] mt [LEN];
    int         mn;

    task automatic check(input string nm, input int act, input int exp);
        checks++;
        if (act == exp) passes++;
        else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    endtask

    function automatic int fl0(input int x);
        return (x < 0) ? 0 : x;
    endfunction

    function automatic int mx(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // Column-by-column Smith-Waterman with affine gaps over the loaded query/target.
    function automatic int model(input int len, input int m, input int mm, input int go, input int ge);
        int L, best, hl, fl, d, e, f, h, dg;
        int hp [LEN];
        int ep [LEN];
        int hc [LEN];
        int ec [LEN];
        L = (len > LEN) ? LEN : len;
        best = 0;
        for (int i = 0; i < LEN; i++) begin hp[i] = 0; ep[i] = 0; hc[i] = 0; ec[i] = 0; end
        for (int j = 0; j < mn; j++) begin
            hl = 0; fl = 0;
            for (int i = 0; i < L; i++) begin
                dg = (i == 0) ? 0 : hp[i-1];
                if (mq[i] == mt[j]) d = (dg + m > MAXS) ? MAXS : dg + m;
                else                d = fl0(dg - mm);
                e = mx(fl0(hp[i] - go), fl0(ep[i] - ge));
                f = mx(fl0(hl - go), fl0(fl - ge));
                h = mx(d, mx(e, f));
                hc[i] = h; ec[i] = e; hl = h; fl = f;
                best = mx(best, h);
            end
            for (int i = 0; i < LEN; i++) begin hp[i] = hc[i]; ep[i] = ec[i]; end
        end
        return best;
    endfunction

    task automatic set_case(input logic [31:0] qbits, input logic [31:0] tbits, input int n);
        for (int i = 0; i < LEN; i++) begin
            mq[i] = qbits[2*i +: 2];
            mt[i] = tbits[2*i +: 2];
        end
        mn = n;
    endtask

    // result_valid must appear exactly at exp_cycle, carrying the model's score.
    always @(negedge clk) begin
        if (rst && (result_valid || cyc == exp_cycle)) begin
            check("result_valid_timing", int'(result_valid), int'(cyc == exp_cycle));
            if (result_valid) check("result_value", int'(result), exp_res);
        end
    end

    task automatic run_job(input string nm, input int len, input int m, input int mm,
                           input int go, input int ge, input int stall, input int lit,
                           input bit poke_start, input bit abort);
        int s_edge, hs, leff, waited, mres;
        bit ok;
        leff = (len > LEN) ? LEN : len;
        exp_cycle = -1;
        for (int i = 0; i < LEN; i++) query[2*i +: 2] = mq[i];
        query_len = LL'(len);
        match = SW'(m); mismatch = SW'(mm); gap_open = SW'(go); gap_extend = SW'(ge);
        mres = model(len, m, mm, go, ge);
        check({nm, "_model"}, mres, lit);
        exp_res = mres;
        start = 1'b1;
        @(negedge clk);
        s_edge = cyc + 1;
        @(posedge clk); #1;
        start = 1'b0;
        query = $urandom; match = SW'($urandom); mismatch = SW'($urandom);
        gap_open = SW'($urandom); gap_extend = SW'($urandom); query_len = LL'($urandom);
        if (leff == 0) begin
            exp_cycle = s_edge;
            repeat (3) begin @(posedge clk); #1; end
        end else begin
            hs = 0;
            for (int b = 0; b < mn; b++) begin
                tif.tgt_valid = 1'b1;
                tif.tgt_data  = mt[b];
                tif.tgt_last  = (b == mn - 1);
                ok = 1'b0;
                waited = 0;
                while (!ok && waited < 20) begin
                    @(negedge clk);
                    if (tif.tgt_ready) begin
                        ok = 1'b1;
                        hs = cyc + 1;
                    end
                    @(posedge clk); #1;
                    waited++;
                end
                tif.tgt_valid = 1'b0;
                if (!ok) begin
                    check({nm, "_ready_timeout"}, 0, 1);
                    return;
                end
                if (b == 0 && abort) begin
                    #2 rst = 1'b0;
                    #1;
                    check({nm, "_abort_busy"}, int'(busy), 0);
                    check({nm, "_abort_result"}, int'(result), 0);
                    check({nm, "_abort_valid"}, int'(result_valid), 0);
                    check({nm, "_abort_ready"}, int'(tif.tgt_ready), 0);
                    repeat (2) @(posedge clk);
                    #1 rst = 1'b1;
                    repeat (LEN + 4) begin @(posedge clk); #1; end
                    return;
                end
                if (b == 0 && poke_start) begin
                    start = 1'b1; query_len = '0;
                    @(posedge clk); #1;
                    start = 1'b0;
                end
                if (b < mn - 1) repeat (stall) begin @(posedge clk); #1; end
            end
            exp_cycle = hs + leff + 1;
            repeat (leff + 4) begin @(posedge clk); #1; end
        end
        check({nm, "_hold"}, int'(result), exp_res);
        check({nm, "_idle"}, int'(busy), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b0; start = 1'b0; query = '0; query_len = '0;
        match = '0; mismatch = '0; gap_open = '0; gap_extend = '0;
        tif.tgt_valid = 1'b0; tif.tgt_data = '0; tif.tgt_last = 1'b0;
        for (int i = 0; i < LEN; i++) begin mq[i] = '0; mt[i] = '0; end
        mn = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_busy", int'(busy), 0);
        check("reset_ready", int'(tif.tgt_ready), 0);
        check("reset_valid", int'(result_valid), 0);
        check("reset_result", int'(result), 0);
        @(posedge clk); #1 rst = 1'b1;
        repeat (2) begin @(posedge clk); #1; end

        set_case(32'h4, 32'h4, 2);
        run_job("exact_ag", 2, 2, 1, 3, 1, 0, 4, 1'b0, 1'b0);
        set_case(32'h0, 32'h2, 1);
        run_job("mismatch_floor", 1, 2, 1, 3, 1, 0, 0, 1'b0, 1'b0);
        set_case(32'h4, 32'h1C, 3);
        run_job("affine_gap", 2, 5, 1, 2, 1, 0, 8, 1'b0, 1'b0);
        set_case(32'h4, 32'h4, 2);
        run_job("backpressure", 2, 2, 1, 3, 1, 3, 4, 1'b0, 1'b0);
        set_case(32'h0, 32'h0, 2);
        run_job("saturation", 2, MAXS, 1, 3, 1, 0, MAXS, 1'b1, 1'b0);
        run_job("len_zero", 0, 2, 1, 3, 1, 0, 0, 1'b0, 1'b0);
        set_case(32'h0, 32'h0, 1);
        run_job("len_clamp", 31, 2, 1, 3, 1, 0, 2, 1'b0, 1'b0);
        set_case(32'h4, 32'h4, 2);
        run_job("abort", 2, 2, 1, 3, 1, 0, 4, 1'b0, 1'b1);
        run_job("rerun_exact", 2, 2, 1, 3, 1, 0, 4, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule

// File: doc/sw_scoring_engine.md
SW_SCORING_ENGINE -- requirements
Module: sw_scoring_engine

Interface
REQ-001 Parameter SCORE_WIDTH, default 12: width of all scores and penalties, unsigned.
REQ-002 Parameter LENGTH, default 16: number of processing elements (PEs), which is also the maximum query length.
REQ-003 Parameter LOG_LENGTH, default floor(log2(LENGTH))+1: width of query_len.
REQ-004 Nucleotide encoding SHALL be A=2'b00, G=2'b01, T=2'b10, C=2'b11.
REQ-005 clk  in  1  single clock; every register SHALL be clocked on the rising edge.
REQ-006 rst  in  1  reset, asynchronous, active-low.
REQ-007 start  in  1  one-cycle job request.
REQ-008 query  in  2*LENGTH  query bases; base i is query[2i+1:2i].
REQ-009 query_len  in  LOG_LENGTH  active PE count, 0..LENGTH.
REQ-010 match, mismatch, gap_open, gap_extend  in  SCORE_WIDTH each  scoring penalties.
REQ-011 tgt_valid  in  1, tgt_ready  out  1, tgt_data  in  2, tgt_last  in  1: target base stream.
REQ-012 result  out  SCORE_WIDTH  best local alignment score.
REQ-013 result_valid  out  1  one-cycle pulse marking a new result.
REQ-014 busy  out  1  high in every state except IDLE.

Function
REQ-015 The FSM SHALL have four states, IDLE, RUN, DRAIN and DONE, with these transitions: IDLE->RUN on start; RUN->DRAIN on the handshake where tgt_last=1; DRAIN->DONE when the drain counter reaches query_len; DONE->IDLE after one cycle.
REQ-016 On start in IDLE, the block SHALL latch query, query_len and the four penalties, clear all PE H/E/F/high registers to 0, and clear result to 0.
REQ-017 start SHALL be ignored while busy=1.
REQ-018 tgt_ready SHALL be 1 only in RUN, and a beat SHALL be accepted only when tgt_valid and tgt_ready are both 1.
REQ-019 Target-stream stall cycles SHALL leave all PE state unchanged.
REQ-020 The j-th accepted target base SHALL be evaluated by PE i exactly i+1 cycles after acceptance, with one register stage per PE.
REQ-021 PE i SHALL compute H(i,j)=max(0, H(i-1,j-1)+s, E(i,j), F(i,j)), where s=match when query base i equals the target base and s=-mismatch otherwise.
REQ-022 PE i SHALL compute E(i,j)=max(H(i,j-1)-gap_open, E(i,j-1)-gap_extend) and F(i,j)=max(H(i-1,j)-gap_open, F(i-1,j)-gap_extend).
REQ-023 Boundary values H(-1,*), F(-1,*), H(*,-1) and E(*,-1) SHALL all be 0.
REQ-024 Every subtraction SHALL floor at 0.
REQ-025 Every addition SHALL saturate at 2^SCORE_WIDTH-1, with no wrap-around.
REQ-026 Each PE SHALL carry a running high = max(high from the left neighbour, own H).
REQ-027 PEs with index >= query_len SHALL be inactive and SHALL not affect the result.
REQ-028 result SHALL equal the high value of PE query_len-1 after the last target base has passed through it.
REQ-029 result SHALL be registered on the DRAIN->DONE transition and result_valid SHALL be 1 in DONE, i.e. exactly query_len+1 cycles after the tgt_last handshake.
REQ-030 result SHALL hold its value until the next start or reset.
REQ-031 start with query_len=0 SHALL skip RUN and DRAIN, go directly to DONE, and produce result=0 with result_valid one cycle after start.
REQ-032 query_len > LENGTH SHALL be treated as LENGTH.
REQ-033 A single-beat target (tgt_last on the first beat) SHALL be valid input.
REQ-034 Penalty or query input changes while busy=1 SHALL have no effect on the current job.

Reset
REQ-035 While rst=0, FSM=IDLE, tgt_ready=0, busy=0, result_valid=0, result=0, and all PE registers=0, all asynchronously.
REQ-036 Reset asserted mid-job SHALL abort the job, and no result_valid SHALL follow.
REQ-037 After rst deasserts, the next start SHALL run a normal job with no residue from the aborted job.

Verification
REQ-038 Exact match: query=AG, len 2, match=2, mismatch=1, open=3, ext=1; target A,G(last) streamed back-to-back -> result=4, result_valid exactly 3 cycles after the G handshake.
REQ-039 Mismatch floor: query=A, len 1, target T(last), mismatch=1 -> result=0, result_valid 2 cycles after the handshake.
REQ-040 Affine gap: query=AG, len 2, match=5, mismatch=1, open=2, ext=1; target A,C,G(last) -> result=8.
REQ-041 Backpressure: repeat the REQ-038 job with tgt_valid low for 3 cycles between the two beats -> result=4, and the latency to result_valid is measured from the last handshake.
REQ-042 Saturation: SCORE_WIDTH=12, match=4095, query=AA, len 2, target A,A(last) -> result=4095; start during the job is ignored; query_len=0 -> result=0 one cycle after start.
REQ-043 Reset mid-RUN: pulse rst low after the first beat -> busy=0, result=0, no result_valid; rerunning the REQ-038 job then yields result=4.
